// File: rtl/lcd_pkg.sv
// ---------------------------------------------------------------------------
// lcd_pkg
// Shared definitions for the character-LCD write arbiter:
//   - lcd_state_t : controller state encoding
//   - LCD_T_*     : default timing constants in 50 MHz clock cycles
//   - LCD_CNT_W   : down-counter width needed for the default timings
//   - helpers     : max_int, cnt_width, is_slow_cmd
// ---------------------------------------------------------------------------
package lcd_pkg;

    typedef enum logic [3:0] {
        PWRUP,
        INIT_SU,
        INIT_PULSE,
        INIT_WAIT,
        IDLE,
        SU_HI,
        PULSE_HI,
        GAP,
        SU_LO,
        PULSE_LO,
        EXEC
    } lcd_state_t;

    localparam int LCD_T_PWRUP = 750000;
    localparam int LCD_T_INIT1 = 205000;
    localparam int LCD_T_INIT2 = 5000;
    localparam int LCD_T_CMD   = 2000;
    localparam int LCD_T_CLEAR = 82000;
    localparam int LCD_T_SU    = 2;
    localparam int LCD_T_EW    = 12;
    localparam int LCD_T_GAP   = 50;

    localparam int LCD_CNT_W   = 20;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Bits needed to hold the value v itself (counter is loaded with v).
    function automatic int cnt_width(input int v);
        return (v < 2) ? 1 : $clog2(v + 1);
    endfunction

    // Clear display (0x01) and return home (0x02/0x03) need the long execute wait.
    function automatic logic is_slow_cmd(input logic rs, input logic [7:0] data);
        return !rs && ((data == 8'h01) || (data == 8'h02) || (data == 8'h03));
    endfunction

endpackage

// File: rtl/lcd_rr_arbiter.sv
// ---------------------------------------------------------------------------
// lcd_rr_arbiter
// Two-way round-robin grant.
//   valid[1:0]  in  : request lines of requester 1 and 0
//   last_grant  in  : index of the requester granted last (0 or 1)
//   grant[1:0]  out : one-hot grant, all zero when nobody is valid
// ---------------------------------------------------------------------------
module lcd_rr_arbiter (
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic [1:0] grant
);

    // With both requesters pending the one that was not served last wins;
    // a lone requester is always granted.
    always_comb begin
        grant = 2'b00;
        if (valid == 2'b11) begin
            grant = last_grant ? 2'b01 : 2'b10;
        end else if (valid[0]) begin
            grant = 2'b01;
        end else if (valid[1]) begin
            grant = 2'b10;
        end
    end

endmodule

// File: rtl/lcd_write_arbiter.sv
// ---------------------------------------------------------------------------
// lcd_write_arbiter
// Runs the 4-bit LCD power-up init, then accepts byte writes from two
// requesters (round-robin) and sends each as two nibble strobes followed by
// an execute wait.
//   clk, reset            : clock, asynchronous active-high reset
//   reqN_valid/rs/data    : write request (rs 0 = command, 1 = data)
//   reqN_ready            : combinational accept, transfer on valid & ready
//   busy                  : high whenever the controller is not IDLE
//   init_done             : power-up init sequence finished
//   sf_e, lcd_rw          : constant 1 / constant 0
//   lcd_e, lcd_rs, lcd_db : LCD strobe, register select, data nibble
// ---------------------------------------------------------------------------
module lcd_write_arbiter
    import lcd_pkg::*;
#(
    parameter int T_PWRUP = LCD_T_PWRUP,
    parameter int T_INIT1 = LCD_T_INIT1,
    parameter int T_INIT2 = LCD_T_INIT2,
    parameter int T_CMD   = LCD_T_CMD,
    parameter int T_CLEAR = LCD_T_CLEAR,
    parameter int T_SU    = LCD_T_SU,
    parameter int T_EW    = LCD_T_EW,
    parameter int T_GAP   = LCD_T_GAP
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0_valid,
    input  logic       req0_rs,
    input  logic [7:0] req0_data,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic       req1_rs,
    input  logic [7:0] req1_data,
    output logic       req1_ready,
    output logic       busy,
    output logic       init_done,
    output logic       sf_e,
    output logic       lcd_e,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic [3:0] lcd_db
);

    localparam int T_MAX = max_int(max_int(max_int(T_PWRUP, T_INIT1), max_int(T_INIT2, T_CMD)),
                                   max_int(max_int(T_CLEAR, T_SU), max_int(T_EW, T_GAP)));
    localparam int CNT_W = max_int(cnt_width(T_MAX), LCD_CNT_W);

    lcd_state_t       state;
    lcd_state_t       state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_load;
    logic             cnt_expired;
    logic [1:0]       init_idx;
    logic             init_done_q;
    logic [3:0]       init_nibble;
    logic             lat_rs;
    logic [7:0]       lat_data;
    logic             last_grant;
    logic [1:0]       grant;
    logic             transfer;

    lcd_rr_arbiter u_arb (
        .valid      ({req1_valid, req0_valid}),
        .last_grant (last_grant),
        .grant      (grant)
    );

    assign cnt_expired = (cnt <= CNT_W'(1));
    assign init_nibble = (init_idx == 2'd3) ? 4'h2 : 4'h3;
    assign req0_ready  = (state == IDLE) && init_done_q && grant[0];
    assign req1_ready  = (state == IDLE) && init_done_q && grant[1];
    assign transfer    = req0_ready || req1_ready;
    assign init_done   = init_done_q;
    assign sf_e        = 1'b1;
    assign lcd_rw      = 1'b0;

    // State register plus the single down-counter. The counter is reloaded
    // with the new state's duration on every state change and otherwise
    // counts down to 1, which marks the last cycle of the state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= PWRUP;
            cnt   <= CNT_W'(T_PWRUP);
        end else begin
            state <= state_next;
            if (state_next != state) begin
                cnt <= cnt_load;
            end else if (!cnt_expired) begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

    // Next-state logic: timed states advance when the counter expires, IDLE
    // leaves only on an accepted write. The init loop runs four times.
    always_comb begin
        state_next = state;
        case (state)
            PWRUP:      if (cnt_expired) state_next = INIT_SU;
            INIT_SU:    if (cnt_expired) state_next = INIT_PULSE;
            INIT_PULSE: if (cnt_expired) state_next = INIT_WAIT;
            INIT_WAIT:  if (cnt_expired) state_next = (init_idx == 2'd3) ? IDLE : INIT_SU;
            IDLE:       if (transfer)    state_next = SU_HI;
            SU_HI:      if (cnt_expired) state_next = PULSE_HI;
            PULSE_HI:   if (cnt_expired) state_next = GAP;
            GAP:        if (cnt_expired) state_next = SU_LO;
            SU_LO:      if (cnt_expired) state_next = PULSE_LO;
            PULSE_LO:   if (cnt_expired) state_next = EXEC;
            EXEC:       if (cnt_expired) state_next = IDLE;
            default:    state_next = PWRUP;
        endcase
    end

    // Duration loaded on entry to the next state. The init wait depends on
    // which nibble was just sent, the execute wait on the latched byte.
    always_comb begin
        cnt_load = CNT_W'(1);
        case (state_next)
            PWRUP:                     cnt_load = CNT_W'(T_PWRUP);
            INIT_SU, SU_HI, SU_LO:     cnt_load = CNT_W'(T_SU);
            INIT_PULSE, PULSE_HI,
            PULSE_LO:                  cnt_load = CNT_W'(T_EW);
            GAP:                       cnt_load = CNT_W'(T_GAP);
            INIT_WAIT: begin
                case (init_idx)
                    2'd0:    cnt_load = CNT_W'(T_INIT1);
                    2'd1:    cnt_load = CNT_W'(T_INIT2);
                    default: cnt_load = CNT_W'(T_CMD);
                endcase
            end
            EXEC:    cnt_load = is_slow_cmd(lat_rs, lat_data) ? CNT_W'(T_CLEAR) : CNT_W'(T_CMD);
            default: cnt_load = CNT_W'(1);
        endcase
    end

    // Bookkeeping beside the FSM: init nibble index, init_done flag, the
    // latched write and the round-robin pointer. Reset discards any pending
    // write and points the arbiter at requester 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            init_idx    <= 2'd0;
            init_done_q <= 1'b0;
            lat_rs      <= 1'b0;
            lat_data    <= 8'h00;
            last_grant  <= 1'b1;
        end else begin
            if ((state == INIT_WAIT) && cnt_expired) begin
                init_idx <= init_idx + 2'd1;
                if (init_idx == 2'd3) begin
                    init_done_q <= 1'b1;
                end
            end
            if (transfer) begin
                lat_rs     <= req1_ready ? req1_rs : req0_rs;
                lat_data   <= req1_ready ? req1_data : req0_data;
                last_grant <= req1_ready;
            end
        end
    end

    // LCD pins decoded from the state. rs/db are presented during the setup
    // state and held through the strobe; lcd_e is only high in pulse states,
    // so an asynchronous reset drops it at once.
    always_comb begin
        busy   = (state != IDLE);
        lcd_e  = 1'b0;
        lcd_rs = 1'b0;
        lcd_db = 4'h0;
        case (state)
            INIT_SU, INIT_PULSE: begin
                lcd_db = init_nibble;
                lcd_e  = (state == INIT_PULSE);
            end
            SU_HI, PULSE_HI: begin
                lcd_db = lat_data[7:4];
                lcd_rs = lat_rs;
                lcd_e  = (state == PULSE_HI);
            end
            GAP: begin
                lcd_rs = lat_rs;
            end
            SU_LO, PULSE_LO: begin
                lcd_db = lat_data[3:0];
                lcd_rs = lat_rs;
                lcd_e  = (state == PULSE_LO);
            end
            default: begin
                lcd_e = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_lcd_write_arbiter.sv
// ---------------------------------------------------------------------------
// tb_lcd_write_arbiter
// Scoreboarded bench for lcd_write_arbiter with short timings. A cycle-count
// reference model predicts ready/busy/init_done and pushes expected nibble
// strobes into a queue; a separate monitor pops them as lcd_e pulses finish.
// ---------------------------------------------------------------------------
module tb_lcd_write_arbiter;

    localparam int T_PWRUP = 10;
    localparam int T_INIT1 = 5;
    localparam int T_INIT2 = 3;
    localparam int T_CMD   = 4;
    localparam int T_CLEAR = 8;
    localparam int T_SU    = 1;
    localparam int T_EW    = 2;
    localparam int T_GAP   = 3;
    localparam int INIT_LEN = T_PWRUP + 4 * (T_SU + T_EW) + T_INIT1 + T_INIT2 + 2 * T_CMD;

    typedef struct {
        logic       rs;
        logic [3:0] nib;
    } nib_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       req0_valid = 1'b0;
    logic       req0_rs = 1'b0;
    logic [7:0] req0_data = 8'h00;
    logic       req1_valid = 1'b0;
    logic       req1_rs = 1'b0;
    logic [7:0] req1_data = 8'h00;
    logic       req0_ready;
    logic       req1_ready;
    logic       busy;
    logic       init_done;
    logic       sf_e;
    logic       lcd_e;
    logic       lcd_rs;
    logic       lcd_rw;
    logic [3:0] lcd_db;

    int   tests = 0;
    int   fails = 0;
    nib_t exp_q[$];
    int   order_q[$];
    bit   fire0 = 1'b0;
    bit   fire1 = 1'b0;

    int   init_left = INIT_LEN;
    int   busy_left = 0;
    int   last_g = 1;

    bit         in_pulse = 1'b0;
    int         width = 0;
    bit         stable = 1'b1;
    logic [3:0] cap_db = 4'h0;
    logic       cap_rs = 1'b0;
    logic [3:0] prev_db = 4'h0;
    logic       prev_rs = 1'b0;

    lcd_write_arbiter #(
        .T_PWRUP (T_PWRUP),
        .T_INIT1 (T_INIT1),
        .T_INIT2 (T_INIT2),
        .T_CMD   (T_CMD),
        .T_CLEAR (T_CLEAR),
        .T_SU    (T_SU),
        .T_EW    (T_EW),
        .T_GAP   (T_GAP)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_rs    (req0_rs),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_rs    (req1_rs),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .busy       (busy),
        .init_done  (init_done),
        .sf_e       (sf_e),
        .lcd_e      (lcd_e),
        .lcd_rs     (lcd_rs),
        .lcd_rw     (lcd_rw),
        .lcd_db     (lcd_db)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] rand_byte();
        if ($urandom_range(3) == 0) begin
            return 8'($urandom_range(3, 1));
        end
        return 8'($urandom_range(255));
    endfunction

    // Record which requester completed a handshake on the edge that follows.
    initial begin
        forever begin
            @(negedge clk);
            fire0 = req0_valid && req0_ready;
            fire1 = req1_valid && req1_ready;
        end
    end

    // Reference model: the controller is unavailable for INIT_LEN cycles after
    // reset and for a fixed number of cycles after each accepted write. When
    // available it grants round-robin and queues the two nibbles it expects.
    initial begin
        logic [1:0] exp_rdy;
        logic       idle;
        logic       r;
        logic [7:0] d;
        nib_t       e;
        int         g;
        forever begin
            @(negedge clk);
            exp_rdy = 2'b00;
            if (reset) begin
                init_left = INIT_LEN;
                busy_left = 0;
                last_g    = 1;
                checkOutput("reset_lcd_e", 32'(lcd_e), 32'(0));
                checkOutput("reset_lcd_rs", 32'(lcd_rs), 32'(0));
                checkOutput("reset_lcd_db", 32'(lcd_db), 32'(0));
            end
            idle = !reset && (init_left == 0) && (busy_left == 0);
            checkOutput("sf_e", 32'(sf_e), 32'(1));
            checkOutput("lcd_rw", 32'(lcd_rw), 32'(0));
            checkOutput("init_done", 32'(init_done), 32'(!reset && (init_left == 0)));
            checkOutput("busy", 32'(busy), 32'(!idle));
            if (!reset) begin
                if (init_left > 0) init_left--;
                else if (busy_left > 0) busy_left--;
            end
            if (idle) begin
                g = -1;
                if (req0_valid && req1_valid) g = (last_g == 0) ? 1 : 0;
                else if (req0_valid) g = 0;
                else if (req1_valid) g = 1;
                if (g >= 0) begin
                    exp_rdy[g] = 1'b1;
                    last_g = g;
                    r = (g == 0) ? req0_rs : req1_rs;
                    d = (g == 0) ? req0_data : req1_data;
                    busy_left = 2 * T_SU + 2 * T_EW + T_GAP +
                                ((!r && d >= 8'h01 && d <= 8'h03) ? T_CLEAR : T_CMD);
                    e.rs = r; e.nib = d[7:4]; exp_q.push_back(e);
                    e.rs = r; e.nib = d[3:0]; exp_q.push_back(e);
                end
            end
            checkOutput("req0_ready", 32'(req0_ready), 32'(exp_rdy[0]));
            checkOutput("req1_ready", 32'(req1_ready), 32'(exp_rdy[1]));
        end
    end

    // Monitor: measure each lcd_e pulse, check setup and hold of rs/db, and
    // compare the strobed nibble against the next expected one.
    initial begin
        nib_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                in_pulse = 1'b0;
            end else if (lcd_e && !in_pulse) begin
                in_pulse = 1'b1;
                width    = 1;
                cap_db   = lcd_db;
                cap_rs   = lcd_rs;
                stable   = (prev_db == lcd_db) && (prev_rs == lcd_rs);
            end else if (lcd_e) begin
                width++;
                if ((lcd_db != cap_db) || (lcd_rs != cap_rs)) stable = 1'b0;
            end else if (in_pulse) begin
                in_pulse = 1'b0;
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("[TB] FAIL unexpected_pulse: db=%0h rs=%0b with nothing expected at %0t",
                             cap_db, cap_rs, $time);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("pulse_db", 32'(cap_db), 32'(e.nib));
                    checkOutput("pulse_rs", 32'(cap_rs), 32'(e.rs));
                    checkOutput("pulse_width", 32'(width), 32'(T_EW));
                    checkOutput("pulse_setup_hold", 32'(stable), 32'(1));
                end
            end
            prev_db = lcd_db;
            prev_rs = lcd_rs;
        end
    end

    task automatic applyReset();
        nib_t e;
        reset = 1'b1;
        #1;
        checkOutput("lcd_e_on_reset", 32'(lcd_e), 32'(0));
        checkOutput("init_done_on_reset", 32'(init_done), 32'(0));
        exp_q.delete();
        repeat (3) tick();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            e.rs  = 1'b0;
            e.nib = (i < 3) ? 4'h3 : 4'h2;
            exp_q.push_back(e);
        end
    endtask

    task automatic applyStimulus(input int n, input logic rs, input logic [7:0] d);
        bit done = 1'b0;
        if (n == 0) begin
            req0_valid = 1'b1; req0_rs = rs; req0_data = d;
        end else begin
            req1_valid = 1'b1; req1_rs = rs; req1_data = d;
        end
        for (int i = 0; i < 200 && !done; i++) begin
            tick();
            if ((n == 0 && fire0) || (n == 1 && fire1)) done = 1'b1;
        end
        if (n == 0) req0_valid = 1'b0;
        else        req1_valid = 1'b0;
        if (!done) begin
            tests++;
            fails++;
            $display("[TB] FAIL accept_timeout: req%0d got no ready within 200 cycles", n);
        end
    endtask

    initial begin
        bit saw_e;
        #2;
        applyReset();
        repeat (INIT_LEN + 5) tick();

        applyStimulus(0, 1'b1, 8'h41);
        applyStimulus(1, 1'b0, 8'h01);
        applyStimulus(1, 1'b0, 8'h28);

        req0_valid = 1'b1; req0_rs = 1'b1; req0_data = 8'h41;
        req1_valid = 1'b1; req1_rs = 1'b1; req1_data = 8'h42;
        for (int i = 0; i < 300 && order_q.size() < 4; i++) begin
            tick();
            if (fire0) order_q.push_back(0);
            if (fire1) order_q.push_back(1);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        checkOutput("contention_grants", 32'(order_q.size()), 32'(4));
        for (int i = 0; i < order_q.size(); i++) begin
            checkOutput("grant_order", 32'(order_q[i]), 32'(i % 2));
        end

        repeat (20) tick();
        req0_valid = 1'b1; req0_rs = 1'b1; req0_data = 8'h41;
        for (int i = 0; i < 50 && !fire0; i++) tick();
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_rs = 1'b1; req1_data = 8'h55;
        saw_e = 1'b0;
        for (int i = 0; i < 10 && !saw_e; i++) begin
            if (lcd_e) saw_e = 1'b1;
            else tick();
        end
        checkOutput("reached_pulse_hi", 32'(saw_e), 32'(1));
        applyReset();
        applyStimulus(1, 1'b1, 8'h55);

        applyStimulus(0, 1'b0, 8'h02);
        repeat (3) tick();
        req1_valid = 1'b1; req1_rs = 1'b1; req1_data = 8'h77;
        repeat (5) tick();
        req1_valid = 1'b0;
        repeat (20) tick();

        for (int c = 0; c < 1500; c++) begin
            tick();
            if (fire0) req0_valid = 1'b0;
            else if (req0_valid && $urandom_range(19) == 0) req0_valid = 1'b0;
            else if (!req0_valid && $urandom_range(3) == 0) begin
                req0_valid = 1'b1; req0_rs = 1'($urandom_range(1)); req0_data = rand_byte();
            end
            if (fire1) req1_valid = 1'b0;
            else if (req1_valid && $urandom_range(19) == 0) req1_valid = 1'b0;
            else if (!req1_valid && $urandom_range(3) == 0) begin
                req1_valid = 1'b1; req1_rs = 1'($urandom_range(1)); req1_data = rand_byte();
            end
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (40) tick();
        checkOutput("queue_drained", 32'(exp_q.size()), 32'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
